cp0_ctrl: RTL and testbench

//  MEM-stage System Control Coprocessor (CP0) register file and exception sequencer. Holds

---
 rtl/cp0_ctrl_pkg.sv | 61 ++++++
 rtl/cp0_ctrl_timer.sv | 46 ++++
 rtl/cp0_ctrl.sv | 138 +++++++++++++
 tb/tb_cp0_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 constants: exception type codes, register numbers, ExcCodes, bit positions.
// Also holds the except_type -> ExcCode decoder used by the sequencer.
package cp0_ctrl_pkg;

    localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;

    localparam logic [31:0] EXC_TYPE_NOEXC = 32'h0000_0000;
    localparam logic [31:0] EXC_TYPE_INT   = 32'h0000_0001;
    localparam logic [31:0] EXC_TYPE_ADEL  = 32'h0000_0004;
    localparam logic [31:0] EXC_TYPE_ADES  = 32'h0000_0005;
    localparam logic [31:0] EXC_TYPE_SYS   = 32'h0000_0008;
    localparam logic [31:0] EXC_TYPE_BP    = 32'h0000_0009;
    localparam logic [31:0] EXC_TYPE_RI    = 32'h0000_000a;
    localparam logic [31:0] EXC_TYPE_OV    = 32'h0000_000c;
    localparam logic [31:0] EXC_TYPE_ERET  = 32'h0000_000e;

    localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_REG_EPC      = 5'd14;

    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0a;
    localparam logic [4:0] EXCCODE_OV   = 5'h0c;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int STATUS_BEV = 22;
    localparam int CAUSE_BD   = 31;
    localparam int CAUSE_TI   = 30;

    typedef struct packed {
        logic       vld;
        logic [4:0] code;
    } exc_dec_t;

    // Unknown type codes decode as not-valid: they still discard a same-cycle mtc0.
    function automatic exc_dec_t exc_decode(input logic [31:0] t);
        exc_dec_t d;
        d.vld  = 1'b1;
        d.code = EXCCODE_INT;
        case (t)
            EXC_TYPE_INT:  d.code = EXCCODE_INT;
            EXC_TYPE_ADEL: d.code = EXCCODE_ADEL;
            EXC_TYPE_ADES: d.code = EXCCODE_ADES;
            EXC_TYPE_SYS:  d.code = EXCCODE_SYS;
            EXC_TYPE_BP:   d.code = EXCCODE_BP;
            EXC_TYPE_RI:   d.code = EXCCODE_RI;
            EXC_TYPE_OV:   d.code = EXCCODE_OV;
            default:       d.vld  = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cp0_ctrl_timer.sv
// CP0 Count/Compare timer: prescaler, Count, Compare and the timer-interrupt flag TI.
module cp0_ctrl_timer #(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(COUNT_DIV - 1);

    logic [DW-1:0] div_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q   <= '0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            if (count_we) begin
                count <= wdata;
                div_q <= '0;
            end else if (div_q == DIV_LAST) begin
                count <= count + 32'd1;
                div_q <= '0;
            end else begin
                div_q <= div_q + DW'(1);
            end
            // Writing Compare acknowledges the interrupt and beats a same-edge match.
            if (compare_we) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (count == compare && compare != 32'd0) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_ctrl.sv
// MEM-stage CP0 register file and exception sequencer.
// Macro CP0_TIMER_EN enables Count/Compare/TI; undefined ties them to zero.
module cp0_ctrl
    import cp0_ctrl_pkg::*;
#(
    parameter int unsigned COUNT_DIV  = 2,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [31:0] except_type_i,
    input  logic [31:0] pc_i,
    input  logic        in_dslot_i,
    input  logic [31:0] badvaddr_i,
    input  logic [5:0]  int_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        timer_int_o
);

    logic [7:0]  im_q;
    logic        exl_q, ie_q;
    logic        bd_q;
    logic [5:0]  ip_hw_q;
    logic [1:0]  ip_sw_q;
    logic [4:0]  exccode_q;
    logic [31:0] epc_q, badvaddr_q;
    logic [31:0] count, compare;
    logic        ti;

    logic     commit, is_eret, wr;
    exc_dec_t dec;

    assign commit  = ~stall_i & (except_type_i != EXC_TYPE_NOEXC);
    assign is_eret = except_type_i == EXC_TYPE_ERET;
    assign dec     = exc_decode(except_type_i);
    // A committing exception discards its own instruction, including any mtc0.
    assign wr      = we_i & ~stall_i & ~commit;

`ifdef CP0_TIMER_EN
    cp0_ctrl_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr && waddr_i == CP0_REG_COUNT),
        .compare_we (wr && waddr_i == CP0_REG_COMPARE),
        .wdata      (wdata_i),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );
`else
    logic unused_div;
    assign unused_div = ^COUNT_DIV;
    assign count      = '0;
    assign compare    = '0;
    assign ti         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            im_q       <= STATUS_RST[15:8];
            exl_q      <= STATUS_RST[STATUS_EXL];
            ie_q       <= STATUS_RST[STATUS_IE];
            bd_q       <= 1'b0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
            exccode_q  <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            ip_hw_q <= {int_i[5] | ti, int_i[4:0]};
            if (commit && is_eret) begin
                exl_q <= 1'b0;
            end else if (commit && dec.vld) begin
                // Nested exception keeps the EPC/BD of the outer one.
                if (!exl_q) begin
                    epc_q <= in_dslot_i ? pc_i - 32'd4 : pc_i;
                    bd_q  <= in_dslot_i;
                end
                exl_q     <= 1'b1;
                exccode_q <= dec.code;
                if (dec.code == EXCCODE_ADEL || dec.code == EXCCODE_ADES)
                    badvaddr_q <= badvaddr_i;
            end else if (wr) begin
                case (waddr_i)
                    CP0_REG_STATUS: begin
                        im_q  <= wdata_i[15:8];
                        exl_q <= wdata_i[STATUS_EXL];
                        ie_q  <= wdata_i[STATUS_IE];
                    end
                    CP0_REG_CAUSE: ip_sw_q <= wdata_i[9:8];
                    CP0_REG_EPC:   epc_q   <= wdata_i;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        status_o             = ZERO_WORD;
        status_o[STATUS_BEV] = 1'b1;
        status_o[15:8]       = im_q;
        status_o[STATUS_EXL] = exl_q;
        status_o[STATUS_IE]  = ie_q;
    end

    always_comb begin
        cause_o           = ZERO_WORD;
        cause_o[CAUSE_BD] = bd_q;
        cause_o[CAUSE_TI] = ti;
        cause_o[15:10]    = ip_hw_q;
        cause_o[9:8]      = ip_sw_q;
        cause_o[6:2]      = exccode_q;
    end

    assign epc_o       = epc_q;
    assign timer_int_o = ti;

    always_comb begin
        case (raddr_i)
            CP0_REG_BADVADDR: rdata_o = badvaddr_q;
            CP0_REG_COUNT:    rdata_o = count;
            CP0_REG_COMPARE:  rdata_o = compare;
            CP0_REG_STATUS:   rdata_o = status_o;
            CP0_REG_CAUSE:    rdata_o = cause_o;
            CP0_REG_EPC:      rdata_o = epc_q;
            default:          rdata_o = ZERO_WORD;
        endcase
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl; the timer section follows CP0_TIMER_EN.
module tb_cp0_ctrl;
    import cp0_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [31:0] except_type_i;
    logic [31:0] pc_i;
    logic        in_dslot_i;
    logic [31:0] badvaddr_i;
    logic [5:0]  int_i;
    logic [31:0] status_o, cause_o, epc_o;
    logic        timer_int_o;

    int vectors = 0;
    int miscompares = 0;

    cp0_ctrl #(.COUNT_DIV(2), .STATUS_RST(32'h0040_0000)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .we_i(we_i), .waddr_i(waddr_i),
        .wdata_i(wdata_i), .raddr_i(raddr_i), .rdata_o(rdata_o),
        .except_type_i(except_type_i), .pc_i(pc_i), .in_dslot_i(in_dslot_i),
        .badvaddr_i(badvaddr_i), .int_i(int_i), .status_o(status_o), .cause_o(cause_o),
        .epc_o(epc_o), .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change after the falling edge; outputs are checked at the next falling edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        raddr_i = a;
        #1;
        chk(tag, rdata_o, exp);
    endtask

    initial begin
        rst = 1'b0; stall_i = 1'b0; we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = '0;
        except_type_i = EXC_TYPE_NOEXC; pc_i = '0; in_dslot_i = 1'b0; badvaddr_i = '0;
        int_i = '0;
        step(2);

        // Reset values
        chk("rst_status", status_o, 32'h0040_0000);
        chk("rst_cause", cause_o, 32'h0);
        chk("rst_epc", epc_o, 32'h0);
        chk("rst_ti", {31'b0, timer_int_o}, 32'h0);
        rst = 1'b1;
        step(1);
        rd(CP0_REG_BADVADDR, "rst_rd8", 32'h0);
        rd(CP0_REG_EPC, "rst_rd14", 32'h0);
        chk("rst_status_run", status_o, 32'h0040_0000);

        // Overflow in a delay slot
        except_type_i = EXC_TYPE_OV; pc_i = 32'hBFC0_1000; in_dslot_i = 1'b1;
        step(1);
        except_type_i = EXC_TYPE_NOEXC; in_dslot_i = 1'b0;
        chk("ov_epc", epc_o, 32'hBFC0_0FFC);
        chk("ov_cause", cause_o, 32'h8000_0030);
        chk("ov_status", status_o, 32'h0040_0002);

        // Nested ADEL keeps EPC/BD, then ERET
        except_type_i = EXC_TYPE_ADEL; pc_i = 32'h8000_0040; badvaddr_i = 32'h1234_5679;
        step(1);
        except_type_i = EXC_TYPE_NOEXC;
        chk("adel_epc", epc_o, 32'hBFC0_0FFC);
        chk("adel_cause", cause_o, 32'h8000_0010);
        rd(CP0_REG_BADVADDR, "adel_badvaddr", 32'h1234_5679);
        except_type_i = EXC_TYPE_ERET; badvaddr_i = 32'hDEAD_BEEF;
        step(1);
        except_type_i = EXC_TYPE_NOEXC;
        chk("eret_status", status_o, 32'h0040_0000);
        chk("eret_epc", epc_o, 32'hBFC0_0FFC);
        rd(CP0_REG_BADVADDR, "eret_badvaddr", 32'h1234_5679);

        // mtc0 discarded by a same-cycle SYS; then stalled; then applied
        we_i = 1'b1; waddr_i = CP0_REG_STATUS; wdata_i = 32'h0000_FF01;
        except_type_i = EXC_TYPE_SYS; pc_i = 32'h8000_0100;
        step(1);
        except_type_i = EXC_TYPE_NOEXC;
        chk("sys_status", status_o, 32'h0040_0002);
        chk("sys_cause", cause_o, 32'h0000_0020);
        chk("sys_epc", epc_o, 32'h8000_0100);
        stall_i = 1'b1;
        step(1);
        chk("stall_status", status_o, 32'h0040_0002);
        stall_i = 1'b0;
        step(1);
        chk("mtc0_status", status_o, 32'h0040_FF01);
        rd(CP0_REG_STATUS, "mfc0_status", 32'h0040_FF01);

        // Cause: only IP1..0 writable; unimplemented register ignored
        waddr_i = CP0_REG_CAUSE; wdata_i = 32'hFFFF_FFFF;
        step(1);
        chk("cause_wr", cause_o, 32'h0000_0320);
        waddr_i = 5'd15; wdata_i = 32'h5555_5555;
        step(1);
        rd(5'd15, "unimpl_rd", 32'h0);
        waddr_i = CP0_REG_EPC; wdata_i = 32'h0000_1234;
        step(1);
        we_i = 1'b0;
        chk("epc_wr", epc_o, 32'h0000_1234);

        // Hardware interrupt lines
        int_i = 6'b000100;
        step(1);
        chk("int_ip", {26'b0, cause_o[15:10]}, 32'h0000_0004);
        int_i = 6'b100000;
        step(1);
        chk("int_ip5", {26'b0, cause_o[15:10]}, 32'h0000_0020);
        int_i = 6'b000000;
        step(1);
        chk("int_clr", cause_o, 32'h0000_0320);

`ifdef CP0_TIMER_EN
        we_i = 1'b1; waddr_i = CP0_REG_COMPARE; wdata_i = 32'd5;
        step(1);
        waddr_i = CP0_REG_COUNT; wdata_i = 32'd0;
        step(1);
        we_i = 1'b0;
        // Count steps every 2 edges: reaches 5 after 10 edges, TI on the 11th
        step(10);
        rd(CP0_REG_COUNT, "tmr_count5", 32'd5);
        chk("tmr_ti_pre", {31'b0, timer_int_o}, 32'h0);
        step(1);
        chk("tmr_ti", {31'b0, timer_int_o}, 32'h1);
        chk("tmr_cause30", {31'b0, cause_o[30]}, 32'h1);
        step(1);
        chk("tmr_cause15", {31'b0, cause_o[15]}, 32'h1);
        we_i = 1'b1; waddr_i = CP0_REG_COMPARE; wdata_i = 32'd100;
        step(1);
        we_i = 1'b0;
        chk("tmr_ti_clr", {31'b0, timer_int_o}, 32'h0);
        rd(CP0_REG_COMPARE, "tmr_compare", 32'd100);
        we_i = 1'b1; waddr_i = CP0_REG_COUNT; wdata_i = 32'hFFFF_FFFF;
        step(1);
        we_i = 1'b0;
        rd(CP0_REG_COUNT, "tmr_wrap_pre", 32'hFFFF_FFFF);
        step(2);
        rd(CP0_REG_COUNT, "tmr_wrap", 32'h0);
`else
        rd(CP0_REG_COUNT, "notmr_rd9", 32'h0);
        we_i = 1'b1; waddr_i = CP0_REG_COMPARE; wdata_i = 32'd1;
        step(1);
        waddr_i = CP0_REG_COUNT; wdata_i = 32'd1;
        step(1);
        we_i = 1'b0;
        step(4);
        rd(CP0_REG_COUNT, "notmr_rd9_wr", 32'h0);
        rd(CP0_REG_COMPARE, "notmr_rd11", 32'h0);
        chk("notmr_ti", {31'b0, timer_int_o}, 32'h0);
`endif

        // Asynchronous reset mid-cycle drops an in-flight commit
        except_type_i = EXC_TYPE_OV; pc_i = 32'h8000_0200;
        #2 rst = 1'b0;
        #1;
        chk("arst_status", status_o, 32'h0040_0000);
        chk("arst_cause", cause_o, 32'h0);
        chk("arst_epc", epc_o, 32'h0);
        step(1);
        chk("arst_hold_epc", epc_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
